// File: rtl/uncrop_filter_pkg.sv
// Shared types and default geometry for the uncrop filter.
// Holds the FSM state enum, origin clamp limits and frame size.
package uncrop_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  localparam int PIXEL_W   = 16;
  localparam int TILE_R    = 48;
  localparam int TILE_C    = 48;
  localparam int FRAME_R   = 100;
  localparam int FRAME_C   = 160;
  localparam int ROW_W     = 10;
  localparam int COL_W     = 10;
  localparam int FILL_PIX  = 0;

  localparam int Y1_MAX    = FRAME_R - TILE_R;
  localparam int X1_MAX    = FRAME_C - TILE_C;
  localparam int FRAME_PIX = FRAME_R * FRAME_C;

endpackage

// File: rtl/uncrop_filter_axis_out_reg.sv
// Single-stage AXI-stream output register for the uncrop filter.
// Ports: load/data in, ready from sink, valid/tdata out, adv = slot free.
module axis_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] tdata,
  output logic         adv
);

  // Slot can take a new beat when empty or draining this cycle.
  assign adv = !valid || ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      tdata <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tdata <= data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uncrop_filter.sv
// Re-embeds a cropped tile at (Y1,X1) into a full raster frame.
// Ports: tile/origin AXI-stream inputs, frame AXI-stream output, frame_done.
module uncrop_filter
  import uncrop_filter_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = PIXEL_W,
  parameter int IN_ROWS          = TILE_R,
  parameter int IN_COLS          = TILE_C,
  parameter int OUT_ROWS         = FRAME_R,
  parameter int OUT_COLS         = FRAME_C,
  parameter int IMG_ROW_BITWIDTH = ROW_W,
  parameter int IMG_COL_BITWIDTH = COL_W,
  parameter int FILL_VALUE       = FILL_PIX
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PIXEL_BIT_WIDTH-1:0]  pixel_in_TDATA,
  input  logic                        pixel_in_TVALID,
  output logic                        pixel_in_TREADY,
  input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
  input  logic                        crop_Y1_TVALID,
  output logic                        crop_Y1_TREADY,
  input  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
  input  logic                        crop_X1_TVALID,
  output logic                        crop_X1_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
  output logic                        pixel_out_TVALID,
  input  logic                        pixel_out_TREADY,
  output logic                        frame_done
);

  localparam int PW = PIXEL_BIT_WIDTH;
  localparam int RW = IMG_ROW_BITWIDTH;
  localparam int CW = IMG_COL_BITWIDTH;

  localparam logic [RW-1:0] Y1_LIM   = RW'(OUT_ROWS - IN_ROWS);
  localparam logic [CW-1:0] X1_LIM   = CW'(OUT_COLS - IN_COLS);
  localparam logic [RW:0]   WIN_R    = (RW+1)'(IN_ROWS);
  localparam logic [CW:0]   WIN_C    = (CW+1)'(IN_COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_COLS - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [PW-1:0] FILL     = PW'(FILL_VALUE);

  state_t        state;
  logic [RW-1:0] y1;
  logic [CW-1:0] x1;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          y1_got;
  logic          x1_got;
  logic          y1_rdy;
  logic          x1_rdy;

  logic          y1_hs;
  logic          x1_hs;
  logic          y1_have;
  logic          x1_have;
  logic [RW-1:0] y1_cl;
  logic [CW-1:0] x1_cl;
  logic          row_in;
  logic          col_in;
  logic          in_win;
  logic          streaming;
  logic          adv;
  logic          load;
  logic          last_px;
  logic [PW-1:0] load_data;

  assign crop_Y1_TREADY = y1_rdy;
  assign crop_X1_TREADY = x1_rdy;

  assign y1_hs   = y1_rdy && crop_Y1_TVALID;
  assign x1_hs   = x1_rdy && crop_X1_TVALID;
  assign y1_have = y1_got || y1_hs;
  assign x1_have = x1_got || x1_hs;

  // Origins past the last legal placement pin to the frame edge.
  assign y1_cl = (crop_Y1_TDATA > Y1_LIM) ? Y1_LIM : crop_Y1_TDATA;
  assign x1_cl = (crop_X1_TDATA > X1_LIM) ? X1_LIM : crop_X1_TDATA;

  // One extra bit so y1 + tile height cannot wrap.
  assign row_in = ({1'b0, row} >= {1'b0, y1}) &&
                  ({1'b0, row} < ({1'b0, y1} + WIN_R));
  assign col_in = ({1'b0, col} >= {1'b0, x1}) &&
                  ({1'b0, col} < ({1'b0, x1} + WIN_C));
  assign in_win = row_in && col_in;

  assign streaming       = (state == STREAM);
  assign pixel_in_TREADY = streaming && adv && in_win;

  // Fill positions advance without waiting on the tile stream.
  assign load      = streaming && adv && (!in_win || pixel_in_TVALID);
  assign load_data = in_win ? pixel_in_TDATA : FILL;
  assign last_px   = (row == ROW_LAST) && (col == COL_LAST);

  // Only the final frame pixel is in flight while in DONE.
  assign frame_done = (state == DONE) && pixel_out_TVALID &&
                      pixel_out_TREADY;

  axis_out_reg #(
    .W(PW)
  ) u_out (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .data (load_data),
    .ready(pixel_out_TREADY),
    .valid(pixel_out_TVALID),
    .tdata(pixel_out_TDATA),
    .adv  (adv)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      y1     <= '0;
      x1     <= '0;
      row    <= '0;
      col    <= '0;
      y1_got <= 1'b0;
      x1_got <= 1'b0;
      y1_rdy <= 1'b0;
      x1_rdy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (y1_hs) y1 <= y1_cl;
          if (x1_hs) x1 <= x1_cl;
          y1_got <= y1_have;
          x1_got <= x1_have;
          if (y1_have && x1_have) begin
            state  <= STREAM;
            row    <= '0;
            col    <= '0;
            y1_rdy <= 1'b0;
            x1_rdy <= 1'b0;
          end else begin
            y1_rdy <= !y1_have;
            x1_rdy <= !x1_have;
          end
        end
        STREAM: begin
          if (load) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= last_px ? '0 : row + ROW_ONE;
            end else begin
              col <= col + COL_ONE;
            end
            if (last_px) state <= DONE;
          end
        end
        DONE: begin
          if (frame_done) begin
            state  <= IDLE;
            y1_got <= 1'b0;
            x1_got <= 1'b0;
            y1_rdy <= 1'b1;
            x1_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uncrop_filter.sv
// Bench for uncrop_filter: directed frames plus a randomized handshake frame.
// Expected frames come from a placement model of tile-in-frame geometry.
module tb_uncrop_filter;

  localparam int NR    = 100;
  localparam int NC    = 160;
  localparam int TR    = 48;
  localparam int TC    = 48;
  localparam int YM    = NR - TR;
  localparam int XM    = NC - TC;
  localparam int NPIX  = NR * NC;
  localparam int NTILE = TR * TC;
  localparam int FILL  = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pixel_in_TDATA = '0;
  logic        pixel_in_TVALID = 1'b0;
  logic        pixel_in_TREADY;
  logic [9:0]  crop_Y1_TDATA = '0;
  logic        crop_Y1_TVALID = 1'b0;
  logic        crop_Y1_TREADY;
  logic [9:0]  crop_X1_TDATA = '0;
  logic        crop_X1_TVALID = 1'b0;
  logic        crop_X1_TREADY;
  logic [15:0] pixel_out_TDATA;
  logic        pixel_out_TVALID;
  logic        pixel_out_TREADY = 1'b0;
  logic        frame_done;

  uncrop_filter dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_in_TDATA  (pixel_in_TDATA),
    .pixel_in_TVALID (pixel_in_TVALID),
    .pixel_in_TREADY (pixel_in_TREADY),
    .crop_Y1_TDATA   (crop_Y1_TDATA),
    .crop_Y1_TVALID  (crop_Y1_TVALID),
    .crop_Y1_TREADY  (crop_Y1_TREADY),
    .crop_X1_TDATA   (crop_X1_TDATA),
    .crop_X1_TVALID  (crop_X1_TVALID),
    .crop_X1_TREADY  (crop_X1_TREADY),
    .pixel_out_TDATA (pixel_out_TDATA),
    .pixel_out_TVALID(pixel_out_TVALID),
    .pixel_out_TREADY(pixel_out_TREADY),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  logic [15:0] tile [NTILE];
  logic [15:0] got  [NPIX];
  logic [15:0] keep [NPIX];

  int out_n;
  int done_n;
  int tin;
  int early;
  int stall_bad;
  int timed_out;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pixel at raster index i when the tile sits at the clamped origin.
  function automatic int gold(input int i, input int y, input int x);
    int r;
    int c;
    int yc;
    int xc;
    r  = i / NC;
    c  = i % NC;
    yc = (y > YM) ? YM : y;
    xc = (x > XM) ? XM : x;
    if (r >= yc && r < yc + TR && c >= xc && c < xc + TC)
      return int'(tile[(r - yc) * TC + (c - xc)]);
    return FILL;
  endfunction

  task automatic check_idle(input string t);
    chk({t, "_out_valid"}, int'(pixel_out_TVALID), 0);
    chk({t, "_out_data"}, int'(pixel_out_TDATA), 0);
    chk({t, "_in_ready"}, int'(pixel_in_TREADY), 0);
    chk({t, "_y1_ready"}, int'(crop_Y1_TREADY), 0);
    chk({t, "_x1_ready"}, int'(crop_X1_TREADY), 0);
    chk({t, "_frame_done"}, int'(frame_done), 0);
  endtask

  task automatic check_frame(input string t, input int y, input int x);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i < NPIX; i++) begin
      if (int'(got[i]) != gold(i, y, x)) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    chk({t, "_frame_done_count"}, done_n, 1);
    chk({t, "_out_count"}, out_n, NPIX);
    chk({t, "_tile_consumed"}, tin, NTILE);
    chk({t, "_first_bad_index"}, first, -1);
    chk({t, "_bad_pixels"}, bad, 0);
  endtask

  // Drives one frame cycle by cycle; after its own origin is taken it may
  // keep presenting the next origin to probe when that gets accepted.
  task automatic run_frame(input int y, input int x, input int ny,
                           input int nx, input bit nxt, input bit rnd,
                           input int stop_at);
    bit y_got;
    bit x_got;
    bit pv_stall;
    logic [15:0] pv_data;
    y_got = 0;
    x_got = 0;
    pv_stall = 0;
    pv_data = '0;
    out_n = 0;
    done_n = 0;
    tin = 0;
    early = 0;
    stall_bad = 0;
    timed_out = 1;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      @(negedge clk);
      crop_Y1_TDATA  = 10'(y_got ? ny : y);
      crop_Y1_TVALID = y_got ? nxt : (rnd ? 1'($urandom_range(1)) : 1'b1);
      crop_X1_TDATA  = 10'(x_got ? nx : x);
      crop_X1_TVALID = x_got ? nxt : (rnd ? 1'($urandom_range(1)) : 1'b1);
      pixel_in_TDATA  = (tin < NTILE) ? tile[tin] : 16'hBEEF;
      pixel_in_TVALID = rnd ? ($urandom_range(7) != 0) : 1'b1;
      pixel_out_TREADY = rnd ? ($urandom_range(7) != 0) : 1'b1;
      #1;
      if (pv_stall && (!pixel_out_TVALID || pixel_out_TDATA !== pv_data))
        stall_bad++;
      pv_stall = pixel_out_TVALID && !pixel_out_TREADY;
      pv_data  = pixel_out_TDATA;
      if (crop_Y1_TVALID && crop_Y1_TREADY) begin
        if (y_got) early++;
        y_got = 1;
      end
      if (crop_X1_TVALID && crop_X1_TREADY) begin
        if (x_got) early++;
        x_got = 1;
      end
      if (pixel_in_TVALID && pixel_in_TREADY) tin++;
      if (pixel_out_TVALID && pixel_out_TREADY) begin
        if (out_n < NPIX) got[out_n] = pixel_out_TDATA;
        out_n++;
      end
      if (frame_done) done_n++;
      if (done_n > 0 || (stop_at > 0 && out_n >= stop_at)) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic pulse_reset(input string t);
    @(negedge clk);
    reset = 1'b0;
    crop_Y1_TVALID = 1'b0;
    crop_X1_TVALID = 1'b0;
    pixel_in_TVALID = 1'b0;
    #1;
    check_idle(t);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int diffs;
    int extra;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NTILE; i++) tile[i] = 16'(i);

    // Abort mid-row 20 of a frame with a reset.
    run_frame(0, 0, 0, 0, 1'b0, 1'b0, 20 * NC + 10);
    chk("partial_timeout", timed_out, 0);
    chk("partial_reach", out_n, 20 * NC + 10);
    pulse_reset("midreset");

    // Origin at 0,0; next origin held during the frame.
    run_frame(0, 0, 52, 112, 1'b1, 1'b0, 0);
    chk("f00_timeout", timed_out, 0);
    check_frame("f00", 0, 0);
    chk("f00_early_origin", early, 0);
    chk("f00_px0", int'(got[0]), 0);
    chk("f00_px47", int'(got[47]), 47);
    chk("f00_px48", int'(got[48]), FILL);
    chk("f00_px160", int'(got[160]), 48);

    // Bottom-right corner placement, again with next origin waiting.
    run_frame(52, 112, 90, 200, 1'b1, 1'b0, 0);
    chk("corner_timeout", timed_out, 0);
    check_frame("corner", 52, 112);
    chk("corner_early_origin", early, 0);
    chk("corner_px_origin", int'(got[52 * NC + 112]), 0);
    chk("corner_px_last", int'(got[NPIX - 1]), 2303);
    chk("corner_px_prev", int'(got[NPIX - 2]), 2302);
    chk("corner_px0", int'(got[0]), FILL);
    for (int i = 0; i < NPIX; i++) keep[i] = got[i];

    // Out-of-range origin must clamp to the same placement.
    run_frame(90, 200, 0, 0, 1'b0, 1'b0, 0);
    chk("clamp_timeout", timed_out, 0);
    check_frame("clamp", 90, 200);
    diffs = 0;
    for (int i = 0; i < NPIX; i++)
      if (got[i] !== keep[i]) diffs++;
    chk("clamp_same_as_corner", diffs, 0);

    extra = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (frame_done) extra++;
    end
    chk("done_single_pulse", extra, 0);

    // Random tile data and random handshakes on every port.
    for (int i = 0; i < NTILE; i++) tile[i] = 16'($urandom);
    run_frame(37, 59, 0, 0, 1'b0, 1'b1, 0);
    chk("rand_timeout", timed_out, 0);
    check_frame("rand", 37, 59);
    chk("rand_stall_stable", stall_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
